rev_gpio_filt: RTL and testbench

//  APB-slave GPIO, next generation: per-pin debounce filter, atomic set/clear/toggle of the

---
 rtl/rev_gpio_filt_pkg.sv | 37 +++
 rtl/rev_gpio_filt_debounce.sv | 47 ++++
 rtl/rev_gpio_filt.sv | 218 +++++++++++++++++++++
 tb/tb_rev_gpio_filt.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rev_gpio_filt_pkg.sv
// Shared definitions for the rev_gpio_filt APB GPIO block.
//   - Word addresses of every register in the map.
//   - Byte-lane write helpers used by the register file. Each helper works on
//     one 8-bit lane with its pstrb bit, so callers can handle any pin count
//     that is a multiple of 8 by looping over the lanes.
package rev_gpio_pkg;

    localparam int unsigned A_MODE     = 0;
    localparam int unsigned A_DIR      = 1;
    localparam int unsigned A_OUT      = 2;
    localparam int unsigned A_IN       = 3;
    localparam int unsigned A_TR_TYPE  = 4;
    localparam int unsigned A_TR_LVL0  = 5;
    localparam int unsigned A_TR_LVL1  = 6;
    localparam int unsigned A_TR_STAT  = 7;
    localparam int unsigned A_IRQ_EN   = 8;
    localparam int unsigned A_OUT_SET  = 9;
    localparam int unsigned A_OUT_CLR  = 10;
    localparam int unsigned A_OUT_TGL  = 11;
    localparam int unsigned A_FILT_EN  = 12;
    localparam int unsigned A_FILT_CNT = 13;
    localparam int unsigned A_RAW_IN   = 14;
    localparam int unsigned A_RSVD     = 15;  // first reserved address

    typedef logic [7:0] lane_t;

    // Plain register write of one byte lane.
    function automatic lane_t apply_pstrb(input lane_t cur, input lane_t wdata, input logic strb);
        return strb ? wdata : cur;
    endfunction

    // Write-one-to-clear of one byte lane.
    function automatic lane_t w1c(input lane_t cur, input lane_t wdata, input logic strb);
        return strb ? (cur & ~wdata) : cur;
    endfunction

endpackage

// File: rtl/rev_gpio_filt_debounce.sv
// Single-pin debounce filter.
//   clk, rst_n : clock, asynchronous active-low reset
//   s          : synchronised pin sample
//   en         : 1 = filter active, 0 = filtered output follows s every cycle
//   filt_cnt   : extra mismatch cycles required before the output follows s
//   filt_o     : filtered pin value
module rev_gpio_debounce #(
    parameter int FILT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s,
    input  logic              en,
    input  logic [FILT_W-1:0] filt_cnt,
    output logic              filt_o
);

    logic              filt_q, filt_d;
    logic [FILT_W-1:0] cnt_q, cnt_d;

    // The >= compare keeps a running count from getting stuck when filt_cnt is
    // lowered beneath it. Once cnt hits its maximum the compare is necessarily
    // true, so the increment never wraps.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (!en) begin
            filt_d = s;
        end else if (s != filt_q) begin
            if (cnt_q >= filt_cnt) filt_d = s;
            else                   cnt_d  = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/rev_gpio_filt.sv
// APB-slave GPIO with per-pin debounce, atomic set/clear/toggle of OUT,
// W1C trigger status with level interrupt, and error on reserved addresses.
//   pclk, prstn            : clock, asynchronous active-low reset
//   psel/penable/paddr/
//   pwrite/pwrdata/pstrb   : APB request (word address, byte strobes)
//   pready/prddata/pslverr : APB response (no wait states, data registered in setup)
//   irq_o                  : level interrupt, |(TR_STAT & IRQ_EN), registered
//   gpio_i                 : asynchronous pad inputs
//   gpio_o/gpio_oe         : registered pad value / output enable
module rev_gpio_filt
    import rev_gpio_pkg::*;
#(
    parameter int GPIO_PINS   = 32,
    parameter int PADDR_SIZE  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 8
) (
    input  logic                   pclk,
    input  logic                   prstn,
    input  logic                   psel,
    input  logic                   penable,
    input  logic [PADDR_SIZE-1:0]  paddr,
    input  logic                   pwrite,
    input  logic [GPIO_PINS-1:0]   pwrdata,
    input  logic [GPIO_PINS/8-1:0] pstrb,
    output logic                   pready,
    output logic [GPIO_PINS-1:0]   prddata,
    output logic                   pslverr,
    output logic                   irq_o,
    input  logic [GPIO_PINS-1:0]   gpio_i,
    output logic [GPIO_PINS-1:0]   gpio_o,
    output logic [GPIO_PINS-1:0]   gpio_oe
);

    localparam int NB = GPIO_PINS / 8;
    typedef logic [GPIO_PINS-1:0] pins_t;

    pins_t mode_q, mode_d, dir_q, dir_d, out_q, out_d;
    pins_t ttype_q, ttype_d, lvl0_q, lvl0_d, lvl1_q, lvl1_d;
    pins_t stat_q, stat_d, irqen_q, irqen_d, filten_q, filten_d;
    pins_t prev_q, prev_d, prddata_q, prddata_d;
    pins_t gpio_o_q, gpio_o_d, gpio_oe_q, gpio_oe_d;
    logic [FILT_W-1:0] filtcnt_q, filtcnt_d;
    logic pslverr_q, pslverr_d, irq_q, irq_d;
    logic [SYNC_STAGES-1:0][GPIO_PINS-1:0] sync_q, sync_d;

    pins_t raw_w, in_w, wmask, rise, fall, tr, rd_mux;
    logic [31:0] addr_w;
    logic setup, access, wr, rsvd;

    function automatic pins_t merge_w(input pins_t cur, input pins_t wd, input logic [NB-1:0] st);
        pins_t r;
        for (int b = 0; b < NB; b++) r[b*8 +: 8] = apply_pstrb(cur[b*8 +: 8], wd[b*8 +: 8], st[b]);
        return r;
    endfunction

    function automatic pins_t clr_w(input pins_t cur, input pins_t wd, input logic [NB-1:0] st);
        pins_t r;
        for (int b = 0; b < NB; b++) r[b*8 +: 8] = w1c(cur[b*8 +: 8], wd[b*8 +: 8], st[b]);
        return r;
    endfunction

    assign addr_w = 32'(paddr);
    assign setup  = psel & ~penable;
    assign access = psel & penable;
    assign wr     = access & pwrite;
    assign rsvd   = (addr_w >= A_RSVD);

    // Strobed write data, used as the bit mask for set/toggle.
    always_comb begin
        wmask = '0;
        for (int b = 0; b < NB; b++) wmask[b*8 +: 8] = pstrb[b] ? pwrdata[b*8 +: 8] : 8'h00;
    end

    // Input synchroniser; the last stage is RAW_IN.
    always_comb begin
        sync_d[0] = gpio_i;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    end
    assign raw_w = sync_q[SYNC_STAGES-1];

    for (genvar n = 0; n < GPIO_PINS; n++) begin : g_pin
        rev_gpio_debounce #(.FILT_W(FILT_W)) u_db (
            .clk      (pclk),
            .rst_n    (prstn),
            .s        (raw_w[n]),
            .en       (filten_q[n]),
            .filt_cnt (filtcnt_q),
            .filt_o   (in_w[n])
        );
    end

    // Triggers look at the filtered input only.
    assign prev_d = in_w;
    assign rise   = in_w & ~prev_q;
    assign fall   = ~in_w & prev_q;
    assign tr     = (ttype_q & ((lvl1_q & rise) | (lvl0_q & fall)))
                  | (~ttype_q & ((lvl1_q & in_w) | (lvl0_q & ~in_w)));

    // Register file writes. Reserved and read-only addresses fall through.
    always_comb begin
        mode_d    = mode_q;
        dir_d     = dir_q;
        out_d     = out_q;
        ttype_d   = ttype_q;
        lvl0_d    = lvl0_q;
        lvl1_d    = lvl1_q;
        irqen_d   = irqen_q;
        filten_d  = filten_q;
        filtcnt_d = filtcnt_q;
        stat_d    = stat_q;
        if (wr) begin
            case (addr_w)
                A_MODE:    mode_d   = merge_w(mode_q, pwrdata, pstrb);
                A_DIR:     dir_d    = merge_w(dir_q, pwrdata, pstrb);
                A_OUT:     out_d    = merge_w(out_q, pwrdata, pstrb);
                A_TR_TYPE: ttype_d  = merge_w(ttype_q, pwrdata, pstrb);
                A_TR_LVL0: lvl0_d   = merge_w(lvl0_q, pwrdata, pstrb);
                A_TR_LVL1: lvl1_d   = merge_w(lvl1_q, pwrdata, pstrb);
                A_TR_STAT: stat_d   = clr_w(stat_q, pwrdata, pstrb);
                A_IRQ_EN:  irqen_d  = merge_w(irqen_q, pwrdata, pstrb);
                A_OUT_SET: out_d    = out_q | wmask;
                A_OUT_CLR: out_d    = clr_w(out_q, pwrdata, pstrb);
                A_OUT_TGL: out_d    = out_q ^ wmask;
                A_FILT_EN: filten_d = merge_w(filten_q, pwrdata, pstrb);
                A_FILT_CNT: begin
                    for (int i = 0; i < FILT_W; i++)
                        filtcnt_d[i] = pstrb[i/8] ? pwrdata[i] : filtcnt_q[i];
                end
                default: ;
            endcase
        end
        // OR-ing after the clear makes a new trigger win over a same-cycle W1C.
        stat_d = stat_d | tr;
    end

    always_comb begin
        case (addr_w)
            A_MODE:     rd_mux = mode_q;
            A_DIR:      rd_mux = dir_q;
            A_OUT:      rd_mux = out_q;
            A_IN:       rd_mux = in_w;
            A_TR_TYPE:  rd_mux = ttype_q;
            A_TR_LVL0:  rd_mux = lvl0_q;
            A_TR_LVL1:  rd_mux = lvl1_q;
            A_TR_STAT:  rd_mux = stat_q;
            A_IRQ_EN:   rd_mux = irqen_q;
            A_FILT_EN:  rd_mux = filten_q;
            A_FILT_CNT: rd_mux = GPIO_PINS'(filtcnt_q);
            A_RAW_IN:   rd_mux = raw_w;
            default:    rd_mux = '0;
        endcase
    end

    // Response is captured in setup and held through the access phase.
    always_comb begin
        prddata_d = prddata_q;
        pslverr_d = 1'b0;
        if (setup) begin
            prddata_d = rd_mux;
            pslverr_d = rsvd;
        end else if (access) begin
            pslverr_d = pslverr_q;
        end
    end

    assign irq_d     = |(stat_q & irqen_q);
    assign gpio_o_d  = out_q & ~mode_q;             // open-drain pins never drive 1
    assign gpio_oe_d = dir_q & ~(mode_q & out_q);   // open-drain releases on 1

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            mode_q    <= '0;
            dir_q     <= '0;
            out_q     <= '0;
            ttype_q   <= '0;
            lvl0_q    <= '0;
            lvl1_q    <= '0;
            stat_q    <= '0;
            irqen_q   <= '0;
            filten_q  <= '0;
            filtcnt_q <= '0;
            prev_q    <= '0;
            prddata_q <= '0;
            pslverr_q <= 1'b0;
            irq_q     <= 1'b0;
            gpio_o_q  <= '0;
            gpio_oe_q <= '0;
            sync_q    <= '0;
        end else begin
            mode_q    <= mode_d;
            dir_q     <= dir_d;
            out_q     <= out_d;
            ttype_q   <= ttype_d;
            lvl0_q    <= lvl0_d;
            lvl1_q    <= lvl1_d;
            stat_q    <= stat_d;
            irqen_q   <= irqen_d;
            filten_q  <= filten_d;
            filtcnt_q <= filtcnt_d;
            prev_q    <= prev_d;
            prddata_q <= prddata_d;
            pslverr_q <= pslverr_d;
            irq_q     <= irq_d;
            gpio_o_q  <= gpio_o_d;
            gpio_oe_q <= gpio_oe_d;
            sync_q    <= sync_d;
        end
    end

    assign pready  = 1'b1;
    assign prddata = prddata_q;
    assign pslverr = pslverr_q;
    assign irq_o   = irq_q;
    assign gpio_o  = gpio_o_q;
    assign gpio_oe = gpio_oe_q;

endmodule

// File: tb/tb_rev_gpio_filt.sv
module tb_rev_gpio_filt;

    localparam int P = 32;
    localparam int A = 4;

    logic           pclk = 1'b0;
    logic           prstn, psel, penable, pwrite;
    logic [A-1:0]   paddr;
    logic [P-1:0]   pwrdata;
    logic [P/8-1:0] pstrb;
    logic           pready, pslverr, irq_o;
    logic [P-1:0]   prddata, gpio_i, gpio_o, gpio_oe;

    int checks   = 0;
    int failures = 0;
    logic [P:0] sb_q[$];   // expected {pslverr, prddata} per read
    logic err;

    rev_gpio_filt #(.GPIO_PINS(P), .PADDR_SIZE(A), .SYNC_STAGES(2), .FILT_W(8)) dut (
        .pclk(pclk), .prstn(prstn), .psel(psel), .penable(penable), .paddr(paddr),
        .pwrite(pwrite), .pwrdata(pwrdata), .pstrb(pstrb), .pready(pready),
        .prddata(prddata), .pslverr(pslverr), .irq_o(irq_o), .gpio_i(gpio_i),
        .gpio_o(gpio_o), .gpio_oe(gpio_oe)
    );

    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [P-1:0] got, input logic [P-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // All bus tasks start and end 1 time unit after a rising edge.
    task automatic apb_write(input logic [A-1:0] a, input logic [P-1:0] d,
                             input logic [P/8-1:0] s, output logic e);
        psel = 1; penable = 0; pwrite = 1; paddr = a; pwrdata = d; pstrb = s;
        @(posedge pclk); #1 penable = 1;
        e = pslverr;
        @(posedge pclk); #1 psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic wr(input logic [A-1:0] a, input logic [P-1:0] d);
        logic e;
        apb_write(a, d, 4'hF, e);
    endtask

    task automatic apb_read(input logic [A-1:0] a, input logic [P-1:0] exp_d, input logic exp_e);
        logic [P:0] exp;
        sb_q.push_back({exp_e, exp_d});
        psel = 1; penable = 0; pwrite = 0; paddr = a;
        @(posedge pclk); #1 penable = 1;
        exp = sb_q.pop_front();
        chk($sformatf("rd_data a=%0d", a), prddata, exp[P-1:0]);
        chk($sformatf("rd_err a=%0d", a), P'(pslverr), P'(exp[P]));
        @(posedge pclk); #1 psel = 0; penable = 0;
    endtask

    initial begin
        prstn = 0; psel = 0; penable = 0; pwrite = 0; paddr = '0;
        pwrdata = '0; pstrb = '0; gpio_i = '0;

        // 1: reset values, full read sweep, reserved address
        repeat (3) @(posedge pclk);
        #1;
        chk("rst gpio_o", gpio_o, 0);
        chk("rst gpio_oe", gpio_oe, 0);
        chk("rst irq", P'(irq_o), 0);
        chk("rst prddata", prddata, 0);
        chk("rst pslverr", P'(pslverr), 0);
        chk("pready", P'(pready), 1);
        prstn = 1;
        @(posedge pclk); #1;
        for (int i = 0; i < 15; i++) apb_read(A'(i), '0, 1'b0);
        apb_read(4'd15, '0, 1'b1);
        apb_read(4'd0, '0, 1'b0);

        // 2: atomic set/clear/toggle and byte strobes
        wr(4'd2, 32'h0000_00F0);
        wr(4'd9, 32'h1);
        wr(4'd10, 32'h10);
        wr(4'd11, 32'h101);
        apb_read(4'd2, 32'h0000_01E0, 1'b0);
        apb_write(4'd2, 32'hFFFF_FFFF, 4'b0010, err);
        apb_read(4'd2, 32'h0000_FFE0, 1'b0);
        apb_read(4'd9, '0, 1'b0);
        chk("pp gpio_o", gpio_o, 32'h0000_FFE0);
        chk("pp gpio_oe", gpio_oe, 0);
        apb_write(4'd3, 32'hFFFF, 4'hF, err);
        chk("ro write err", P'(err), 0);
        apb_read(4'd3, '0, 1'b0);
        apb_write(4'd15, 32'hFFFF_FFFF, 4'hF, err);
        chk("rsvd write err", P'(err), 1);
        apb_read(4'd0, '0, 1'b0);

        // 3: open-drain on pin 0
        wr(4'd2, 32'h0);
        wr(4'd1, 32'h1);
        chk("dir oe before", P'(gpio_oe[0]), 0);
        @(posedge pclk); #1;
        chk("dir oe after", P'(gpio_oe[0]), 1);
        wr(4'd0, 32'h1);
        @(posedge pclk); #1;
        chk("od low oe", P'(gpio_oe[0]), 1);
        chk("od low o", P'(gpio_o[0]), 0);
        wr(4'd2, 32'h1);
        chk("od hi oe before", P'(gpio_oe[0]), 1);
        @(posedge pclk); #1;
        chk("od hi oe", P'(gpio_oe[0]), 0);
        chk("od hi o", P'(gpio_o[0]), 0);

        // 4: debounce on pin 3, FILT_CNT=4
        wr(4'd12, 32'h8);
        wr(4'd13, 32'h4);
        apb_read(4'd13, 32'h4, 1'b0);
        gpio_i[3] = 1;
        repeat (3) @(posedge pclk);
        #1 gpio_i[3] = 0;
        repeat (10) @(posedge pclk);
        #1;
        apb_read(4'd3, '0, 1'b0);
        gpio_i[3] = 1;
        repeat (6) @(posedge pclk);
        #1 chk("filt edge6", P'(dut.in_w[3]), 0);
        @(posedge pclk);
        #1 chk("filt edge7", P'(dut.in_w[3]), 1);
        apb_read(4'd3, 32'h8, 1'b0);
        gpio_i[3] = 0;
        repeat (10) @(posedge pclk);
        #1;
        wr(4'd12, 32'h0);

        // 5: rising-edge trigger on pin 5 with interrupt
        wr(4'd4, 32'h20);
        wr(4'd6, 32'h20);
        wr(4'd8, 32'h20);
        gpio_i[5] = 1;
        repeat (4) @(posedge pclk);
        #1 chk("irq edge4", P'(irq_o), 0);
        @(posedge pclk);
        #1 chk("irq edge5", P'(irq_o), 1);
        apb_read(4'd7, 32'h20, 1'b0);
        gpio_i[5] = 0;
        repeat (5) @(posedge pclk);
        #1;
        wr(4'd7, 32'h20);
        chk("irq before fall", P'(irq_o), 1);
        @(posedge pclk);
        #1 chk("irq after w1c", P'(irq_o), 0);
        apb_read(4'd7, '0, 1'b0);
        gpio_i[5] = 1;          // STAT sets on the 4th edge from here
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        wr(4'd7, 32'h20);       // W1C lands on that same 4th edge
        apb_read(4'd7, 32'h20, 1'b0);
        wr(4'd7, 32'h20);
        wr(4'd8, 32'h0);
        apb_read(4'd7, '0, 1'b0);

        // 6: level-low trigger on pin 7, then reset mid-access
        wr(4'd5, 32'h80);
        repeat (2) @(posedge pclk);
        #1;
        wr(4'd7, 32'h80);
        apb_read(4'd7, 32'h80, 1'b0);
        wr(4'd0, 32'h0);
        wr(4'd1, 32'hFF);
        wr(4'd8, 32'h80);
        repeat (2) @(posedge pclk);
        #1;
        chk("pre-rst irq", P'(irq_o), 1);
        chk("pre-rst oe", gpio_oe, 32'hFF);
        chk("pre-rst o", gpio_o, 32'h1);
        psel = 1; penable = 0; pwrite = 0; paddr = 4'd2;
        @(posedge pclk); #1 penable = 1;
        chk("pre-rst prddata", prddata, 32'h1);
        #2 prstn = 0;
        #1;
        chk("async gpio_o", gpio_o, 0);
        chk("async gpio_oe", gpio_oe, 0);
        chk("async irq", P'(irq_o), 0);
        chk("async prddata", prddata, 0);
        chk("async pslverr", P'(pslverr), 0);
        psel = 0; penable = 0;
        @(posedge pclk); #1 prstn = 1;
        @(posedge pclk); #1;
        apb_read(4'd7, '0, 1'b0);
        apb_read(4'd5, '0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
